// File: rtl/pc_sequencer_pkg.sv
// Shared opcode constants, sequencer state encoding and link-register helper
// for the miniRV program-counter sequencer.
package pc_pkg;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } state_t;

   // x1 (ra) and x5 (t0) are the calling-convention link registers
   function automatic logic is_link(logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode/execute-side bundle for the PC sequencer: control-flow inputs from
// the pipeline and PC, link and prediction status back to it.
interface pc_sequencer_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic             stall;
   logic [6:0]       opcode;
   logic [4:0]       rd;
   logic [4:0]       rs1;
   logic [XLEN-1:0]  imm;
   logic [XLEN-1:0]  rs1_val;
   logic             branch_taken;
   logic             trap;
   logic [XLEN-1:0]  trap_vector;
   logic [XLEN-1:0]  pc_out;
   logic [XLEN-1:0]  link_value;
   logic             fault;
   logic             ret_mispredict;
   logic [CNT_W-1:0] mispredict_cnt;

   modport master (
      output stall, opcode, rd, rs1, imm, rs1_val, branch_taken, trap, trap_vector,
      input  pc_out, link_value, fault, ret_mispredict, mispredict_cnt
   );

   modport slave (
      input  stall, opcode, rd, rs1, imm, rs1_val, branch_taken, trap, trap_vector,
      output pc_out, link_value, fault, ret_mispredict, mispredict_cnt
   );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack. A simultaneous push and pop on a non-empty
// stack replaces the top entry in place, leaving the depth unchanged.
module pc_ras #(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic            pop,
   input  logic [XLEN-1:0] push_data,
   output logic [XLEN-1:0] top_data,
   output logic            empty
);
   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CW    = $clog2(RAS_DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

   logic [XLEN-1:0]  r_mem [RAS_DEPTH];
   logic [PTR_W-1:0] r_top;
   logic [CW-1:0]    r_count;

   logic             w_replace;
   logic             w_push;
   logic             w_pop;
   logic [PTR_W-1:0] w_wr_ptr;

   assign empty     = (r_count == '0);
   assign top_data  = r_mem[r_top];
   assign w_replace = push && pop && !empty;
   assign w_push    = push && !w_replace;
   assign w_pop     = pop && !push && !empty;
   assign w_wr_ptr  = w_replace ? r_top : r_top + PTR_W'(1);

   // Entries need no reset; only pointer and count define what is valid
   always_ff @(posedge clk) begin
      if (w_push || w_replace) begin
         r_mem[w_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_top   <= '0;
         r_count <= '0;
      end else if (w_push) begin
         r_top <= r_top + PTR_W'(1);
         if (r_count != FULL) begin
            r_count <= r_count + CW'(1);
         end
      end else if (w_pop) begin
         r_top   <= r_top - PTR_W'(1);
         r_count <= r_count - CW'(1);
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-boundary PC sequencer: sequential/JAL/JALR/branch/trap redirects,
// stall hold, misaligned-target fault and RAS-based return checking.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              RAS_DEPTH    = 4,
   parameter int              CNT_W        = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   pc_sequencer_if.slave bus
);
   state_t           r_state;
   state_t           w_state_next;
   logic [XLEN-1:0]  r_pc;
   logic [XLEN-1:0]  w_pc_next;
   logic             r_misp;
   logic             w_misp_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;

   logic [XLEN-1:0]  w_link;
   logic [XLEN-1:0]  w_jalr_sum;
   logic [XLEN-1:0]  w_target;
   logic [XLEN-1:0]  w_top_data;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_rd_link;
   logic             w_rs1_link;

   assign w_link     = r_pc + XLEN'(4);
   assign w_jalr_sum = bus.rs1_val + bus.imm;
   assign w_rd_link  = is_link(bus.rd);
   assign w_rs1_link = is_link(bus.rs1);

   always_comb begin
      w_target = w_link;
      case (bus.opcode)
         OP_JALR:   w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
         OP_JAL:    w_target = r_pc + bus.imm;
         OP_BRANCH: w_target = bus.branch_taken ? (r_pc + bus.imm) : w_link;
         default:   w_target = w_link;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_misp_next  = 1'b0;
      w_cnt_next   = r_cnt;
      w_push       = 1'b0;
      w_pop        = 1'b0;
      if (bus.trap) begin
         w_pc_next    = {bus.trap_vector[XLEN-1:2], 2'b00};
         w_state_next = RUN;
      end else if (r_state == FAULT) begin
         w_state_next = FAULT;
      end else if (bus.stall) begin
         w_state_next = RUN;
      end else if (w_target[1:0] != 2'b00) begin
         w_state_next = FAULT;
      end else begin
         w_pc_next = w_target;
         if (bus.opcode == OP_JAL) begin
            w_push = w_rd_link;
         end else if (bus.opcode == OP_JALR) begin
            // Same link register in rd and rs1 is a call, not a coroutine swap
            w_push = w_rd_link;
            w_pop  = w_rs1_link && !(w_rd_link && (bus.rd == bus.rs1));
         end
         if (w_pop && !w_empty) begin
            w_misp_next = (w_top_data != w_target);
            if (w_misp_next && (r_cnt != {CNT_W{1'b1}})) begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
         r_pc    <= RESET_VECTOR;
         r_misp  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         r_misp  <= w_misp_next;
         r_cnt   <= w_cnt_next;
      end
   end

   pc_ras #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push),
      .pop       (w_pop),
      .push_data (w_link),
      .top_data  (w_top_data),
      .empty     (w_empty)
   );

   assign bus.pc_out         = r_pc;
   assign bus.link_value     = w_link;
   assign bus.fault          = (r_state == FAULT);
   assign bus.ret_mispredict = r_misp;
   assign bus.mispredict_cnt = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed test-plan scenarios followed by randomized control flow, all
// checked against a queue-based reference model of the sequencer.
module tb_pc_sequencer;
   localparam int XLEN      = 32;
   localparam int RAS_DEPTH = 4;
   localparam int CNT_W     = 4;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_ALU  = 7'b0010011;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pc_sequencer_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

   pc_sequencer #(
      .XLEN         (XLEN),
      .RESET_VECTOR (32'h0),
      .RAS_DEPTH    (RAS_DEPTH),
      .CNT_W        (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] m_pc;
   logic        m_fault;
   logic        m_misp;
   int          m_cnt;
   logic [31:0] m_ras[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit lnk(input logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

   function automatic logic [4:0] pick_reg(input int k);
      case (k)
         0: return 5'd0;
         1: return 5'd1;
         2: return 5'd5;
         default: return 5'd2;
      endcase
   endfunction

   task automatic model_reset();
      m_pc    = 32'h0;
      m_fault = 1'b0;
      m_misp  = 1'b0;
      m_cnt   = 0;
      m_ras.delete();
   endtask

   task automatic ras_pop(input logic [31:0] tgt);
      logic [31:0] v;
      if (m_ras.size() > 0) begin
         v = m_ras.pop_back();
         m_misp = (v != tgt);
         if (m_misp && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
   endtask

   task automatic ras_push(input logic [31:0] a);
      m_ras.push_back(a);
      if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
   endtask

   task automatic check_all(input string tag);
      check({tag, "_pc"},   64'(bus.pc_out),         64'(m_pc));
      check({tag, "_link"}, 64'(bus.link_value),     64'(m_pc + 32'd4));
      check({tag, "_flt"},  64'(bus.fault),          64'(m_fault));
      check({tag, "_rm"},   64'(bus.ret_mispredict), 64'(m_misp));
      check({tag, "_cnt"},  64'(bus.mispredict_cnt), 64'(m_cnt));
   endtask

   task automatic step(input string tag, input logic st, input logic [6:0] op,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [31:0] imm, input logic [31:0] rv,
                       input logic bt, input logic tr, input logic [31:0] tv);
      logic [31:0] tgt;
      logic [31:0] sum;
      bus.stall = st; bus.opcode = op; bus.rd = rd; bus.rs1 = rs1;
      bus.imm = imm; bus.rs1_val = rv; bus.branch_taken = bt;
      bus.trap = tr; bus.trap_vector = tv;
      sum = rv + imm;
      if (op == OP_JALR)                  tgt = sum & ~32'd1;
      else if (op == OP_JAL)              tgt = m_pc + imm;
      else if (op == OP_BR && bt)         tgt = m_pc + imm;
      else                                tgt = m_pc + 32'd4;
      m_misp = 1'b0;
      if (tr) begin
         m_pc = tv & ~32'd3;
         m_fault = 1'b0;
      end else if (m_fault || st) begin
         m_pc = m_pc;
      end else if (tgt % 4 != 0) begin
         m_fault = 1'b1;
      end else begin
         if (op == OP_JAL && lnk(rd)) ras_push(m_pc + 32'd4);
         if (op == OP_JALR) begin
            if (lnk(rd) && lnk(rs1) && rd != rs1) begin
               ras_pop(tgt);
               ras_push(m_pc + 32'd4);
            end else if (lnk(rs1) && !lnk(rd)) begin
               ras_pop(tgt);
            end else if (lnk(rd)) begin
               ras_push(m_pc + 32'd4);
            end
         end
         m_pc = tgt;
      end
      @(posedge clk);
      #1;
      check_all(tag);
      $display("%-8s op=%b rd=%0d rs1=%0d st=%0d tr=%0d pc=%h flt=%0d rm=%0d cnt=%0d",
               tag, op, rd, rs1, st, tr, bus.pc_out, bus.fault, bus.ret_mispredict,
               bus.mispredict_cnt);
   endtask

   task automatic alu(input string tag);
      step(tag, 1'b0, OP_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic async_reset(input string tag);
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [31:0] ret_addr [5];

   initial begin
      bus.stall = 0; bus.opcode = OP_ALU; bus.rd = 0; bus.rs1 = 0; bus.imm = 0;
      bus.rs1_val = 0; bus.branch_taken = 0; bus.trap = 0; bus.trap_vector = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst_n = 1'b1;

      alu("seq1"); alu("seq2"); alu("seq3");
      check("seq_c", 64'(bus.pc_out), 64'h0000_000C);
      async_reset("rst_mid");
      check("rst_pc0", 64'(bus.pc_out), 64'h0);

      alu("seq4"); alu("seq5");
      step("jal", 0, OP_JAL, 5'd1, 5'd0, 32'h100, 32'd0, 0, 0, 32'd0);
      check("jal_pc", 64'(bus.pc_out), 64'h108);
      step("ret_ok", 0, OP_JALR, 5'd0, 5'd1, 32'd0, 32'hC, 0, 0, 32'd0);
      check("ret_ok_pc", 64'(bus.pc_out), 64'hC);
      check("ret_ok_rm", 64'(bus.ret_mispredict), 64'h0);
      step("jal2", 0, OP_JAL, 5'd1, 5'd0, 32'h100, 32'd0, 0, 0, 32'd0);
      step("ret_bad", 0, OP_JALR, 5'd0, 5'd1, 32'd0, 32'h20, 0, 0, 32'd0);
      check("ret_bad_rm", 64'(bus.ret_mispredict), 64'h1);
      check("ret_bad_cnt", 64'(bus.mispredict_cnt), 64'h1);

      step("br_t", 0, OP_BR, 5'd0, 5'd0, -32'sd8, 32'd0, 1, 0, 32'd0);
      check("br_t_pc", 64'(bus.pc_out), 64'h18);
      alu("seq6"); alu("seq7");
      step("br_nt", 0, OP_BR, 5'd0, 5'd0, -32'sd8, 32'd0, 0, 0, 32'd0);
      check("br_nt_pc", 64'(bus.pc_out), 64'h24);
      for (int i = 0; i < 3; i++)
         step("stall", 1, OP_JAL, 5'd1, 5'd0, 32'h40, 32'd0, 0, 0, 32'd0);
      check("stall_pc", 64'(bus.pc_out), 64'h24);

      step("misal", 0, OP_JALR, 5'd0, 5'd2, 32'd0, 32'h102, 0, 0, 32'd0);
      check("misal_flt", 64'(bus.fault), 64'h1);
      for (int i = 0; i < 5; i++) alu("fhold");
      check("fhold_pc", 64'(bus.pc_out), 64'h24);
      step("trap", 0, OP_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 0, 1, 32'h203);
      check("trap_pc", 64'(bus.pc_out), 64'h200);
      check("trap_flt", 64'(bus.fault), 64'h0);

      for (int i = 0; i < 5; i++) begin
         ret_addr[i] = m_pc + 32'd4;
         step("nest", 0, OP_JAL, 5'd1, 5'd0, 32'h40, 32'd0, 0, 0, 32'd0);
      end
      for (int i = 4; i >= 1; i--) begin
         step("unwind", 0, OP_JALR, 5'd0, 5'd1, 32'd0, ret_addr[i], 0, 0, 32'd0);
         check("unwind_rm", 64'(bus.ret_mispredict), 64'h0);
      end
      step("pop_emp", 0, OP_JALR, 5'd0, 5'd1, 32'd0, ret_addr[0], 0, 0, 32'd0);
      check("pop_emp_rm", 64'(bus.ret_mispredict), 64'h0);

      step("trap2", 0, OP_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 0, 1, 32'h3C);
      step("jal40", 0, OP_JAL, 5'd1, 5'd0, 32'h100, 32'd0, 0, 0, 32'd0);
      step("swap", 0, OP_JALR, 5'd5, 5'd1, 32'd0, 32'h40, 0, 0, 32'd0);
      check("swap_pc", 64'(bus.pc_out), 64'h40);
      step("swapret", 0, OP_JALR, 5'd0, 5'd1, 32'd0, 32'h140, 0, 0, 32'd0);
      check("swapret_rm", 64'(bus.ret_mispredict), 64'h0);
      step("swapemp", 0, OP_JALR, 5'd0, 5'd1, 32'd0, 32'h77C, 0, 0, 32'd0);
      step("trapstl", 1, OP_JAL, 5'd1, 5'd0, 32'h8, 32'd0, 0, 1, 32'h500);
      check("trapstl_pc", 64'(bus.pc_out), 64'h500);

      for (int i = 0; i < 600; i++) begin
         int          sel;
         logic [6:0]  op;
         logic [4:0]  rd;
         logic [4:0]  rs1;
         logic [31:0] imm;
         logic [31:0] rv;
         logic        st;
         logic        tr;
         sel = int'($urandom_range(0, 9));
         op  = (sel < 2) ? OP_JAL : (sel < 5) ? OP_JALR : (sel < 7) ? OP_BR : OP_ALU;
         rd  = pick_reg(int'($urandom_range(0, 3)));
         rs1 = pick_reg(int'($urandom_range(0, 3)));
         imm = 32'($urandom_range(0, 255) * 4) - 32'd512;
         if ($urandom_range(0, 15) == 0) imm = imm + 32'd2;
         if (op == OP_JALR) imm = 32'd0;
         if (m_ras.size() > 0 && $urandom_range(0, 1) == 0) rv = m_ras[$];
         else rv = 32'($urandom_range(0, 4095) * 4);
         if ($urandom_range(0, 7) == 0) rv = rv + 32'd1;
         if ($urandom_range(0, 15) == 0) rv = rv + 32'd2;
         st = ($urandom_range(0, 7) == 0);
         tr = ($urandom_range(0, 11) == 0) || (m_fault && $urandom_range(0, 2) == 0);
         step("rand", st, op, rd, rs1, imm, rv, 1'($urandom_range(0, 1)), tr,
              32'($urandom_range(0, 65535)));
      end
      async_reset("rst_end");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
